// File: rtl/perceptron_seq_pkg.sv
// Shared types and Q8.8 saturating arithmetic for the sequential perceptron.
// Holds the activation selector, the FSM state type and the forward
// activation function (predict) used by the neuron.
package perceptron_seq_pkg;

    typedef logic signed [15:0] sfp;

    localparam sfp SFP_MAX  = 16'sh7FFF;
    localparam sfp SFP_MIN  = 16'sh8000;
    localparam sfp SFP_ZERO = 16'sh0000;
    localparam sfp SFP_ONE  = 16'sh0100;
    localparam sfp SFP_HALF = 16'sh0080;

    typedef enum logic [1:0] {
        ACT_LINEAR  = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_SIGMOID = 2'd2,
        ACT_TANH    = 2'd3
    } act_func;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_MAC       = 4'd1,
        S_ACT       = 4'd2,
        S_OUT       = 4'd3,
        S_WAIT_GRAD = 4'd4,
        S_BACK      = 4'd5,
        S_DERIV     = 4'd6,
        S_UPD       = 4'd7,
        S_INIT      = 4'd8
    } pseq_state_e;

    // Clamp a 17-bit intermediate into the sfp range.
    function automatic sfp sfp_sat17(input logic signed [16:0] s);
        if (s > 17'sd32767)       return SFP_MAX;
        else if (s < -17'sd32768) return SFP_MIN;
        else                      return sfp'(s[15:0]);
    endfunction

    function automatic sfp sfp_add_sat(input sfp a, input sfp b);
        return sfp_sat17(17'(a) + 17'(b));
    endfunction

    function automatic sfp sfp_sub_sat(input sfp a, input sfp b);
        return sfp_sat17(17'(a) - 17'(b));
    endfunction

    // Q8.8 x Q8.8 -> Q8.8, truncated toward zero, saturated.
    function automatic sfp sfp_mul_sat(input sfp a, input sfp b);
        logic signed [31:0] p;
        logic signed [31:0] q;
        p = 32'(a) * 32'(b);
        if (p < 32'sd0) p = p + 32'sd255;
        else            p = p;
        q = p >>> 8;
        if (q > 32'sd32767)       return SFP_MAX;
        else if (q < -32'sd32768) return SFP_MIN;
        else                      return sfp'(q[15:0]);
    endfunction

    // Forward activation. Sigmoid and tanh are piecewise-linear:
    // sigmoid ~ clamp(0.5 + x/4, 0, 1), tanh ~ clamp(x, -1, 1).
    function automatic sfp predict(input act_func f, input sfp x);
        sfp y;
        case (f)
            ACT_RELU: y = (x < SFP_ZERO) ? SFP_ZERO : x;
            ACT_SIGMOID: begin
                y = sfp_add_sat(SFP_HALF, x >>> 2);
                if (y < SFP_ZERO)     y = SFP_ZERO;
                else if (y > SFP_ONE) y = SFP_ONE;
                else                  y = y;
            end
            ACT_TANH: begin
                if (x < -SFP_ONE)     y = -SFP_ONE;
                else if (x > SFP_ONE) y = SFP_ONE;
                else                  y = x;
            end
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/perceptron_seq_if.sv
// Handshake/bus bundle between a layer controller (master) and one neuron (slave).
interface perceptron_seq_if
    import perceptron_seq_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    localparam int IW = $clog2(N_IN + 1);

    logic          in_valid;
    logic          in_ready;
    sfp            in_values [N_IN];
    act_func       activation;
    logic          train;
    sfp            learning_rate;
    logic          out_valid;
    logic          out_ready;
    sfp            prediction;
    logic          grad_valid;
    logic          grad_ready;
    sfp            next_weights [N_OUT];
    sfp            next_grad [N_OUT];
    logic          err_valid;
    sfp            error_gradient;
    logic          wload_en;
    logic [IW-1:0] wload_idx;
    sfp            wload_data;
    sfp            current_weights [N_IN];

    modport master (
        output in_valid, in_values, activation, train, learning_rate, out_ready,
               grad_valid, next_weights, next_grad, wload_en, wload_idx, wload_data,
        input  in_ready, out_valid, prediction, grad_ready, err_valid, error_gradient,
               current_weights
    );

    modport slave (
        input  in_valid, in_values, activation, train, learning_rate, out_ready,
               grad_valid, next_weights, next_grad, wload_en, wload_idx, wload_data,
        output in_ready, out_valid, prediction, grad_ready, err_valid, error_gradient,
               current_weights
    );

endinterface

// File: rtl/perceptron_seq_act_deriv.sv
// Combinational activation-derivative scaling of the backpropagated gradient.
// Derivatives are taken from the prediction (sigmoid, tanh) or the pre-activation
// sum (ReLU); linear activation yields a zero gradient.
module perceptron_seq_act_deriv
    import perceptron_seq_pkg::*;
(
    input  act_func activation,
    input  sfp      prediction,
    input  sfp      sum,
    input  sfp      g,
    output sfp      result
);

    // Select derivative form for the latched activation.
    always_comb begin
        result = SFP_ZERO;
        case (activation)
            ACT_SIGMOID: result = sfp_mul_sat(g, sfp_mul_sat(prediction,
                                      sfp_sub_sat(SFP_ONE, prediction)));
            ACT_TANH:    result = sfp_mul_sat(g, sfp_sub_sat(SFP_ONE,
                                      sfp_mul_sat(prediction, prediction)));
            ACT_RELU:    result = (sum >= SFP_ZERO) ? g : SFP_ZERO;
            default:     result = SFP_ZERO;
        endcase
    end

endmodule

// File: rtl/perceptron_seq.sv
// Sequential perceptron neuron: one time-shared saturating Q8.8 MAC for the
// forward pass, gradient accumulation for backprop and in-place weight update.
// Optional build macro PERCEPTRON_LFSR_INIT_EN: seeds weights and bias from a
// 16-bit LFSR after reset instead of clearing them to zero.
module perceptron_seq
    import perceptron_seq_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
)(
    input logic             clk,
    input logic             rst_n,
    perceptron_seq_if.slave bus
);

    localparam int IW = $clog2(N_IN + 1);
    localparam int OW = $clog2(N_OUT + 1);
`ifdef PERCEPTRON_LFSR_INIT_EN
    localparam pseq_state_e RESET_STATE = S_INIT;
`else
    localparam pseq_state_e RESET_STATE = S_IDLE;
`endif

    pseq_state_e   state_r, state_nx;
    logic [IW-1:0] idx_r;
    logic [OW-1:0] oidx_r;
    sfp            acc_r, pred_r, g_r, err_r, lr_r, bias_r;
    act_func       act_r;
    logic          train_r;
    sfp            vals_r [N_IN];
    sfp            w_r [N_IN];
    sfp            nw_r [N_OUT];
    sfp            ng_r [N_OUT];
    logic          out_valid_r, grad_ready_r, err_valid_r;

    logic          in_ready_s, in_hs_s, mac_last_s, upd_last_s, back_last_s;
    sfp            w_sel_s, v_sel_s, nw_sel_s, ng_sel_s, term_s, lrg_s, upd_new_s, deriv_s;
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    sfp            wr_data_s;

    assign in_ready_s  = (state_r == S_IDLE) && !bus.wload_en;
    assign in_hs_s     = bus.in_valid && in_ready_s;
    assign mac_last_s  = (idx_r == IW'(N_IN - 1));
    assign upd_last_s  = (idx_r == IW'(N_IN));
    assign back_last_s = (oidx_r == OW'(N_OUT - 1));

    // Operand muxes for the shared MAC / update path.
    always_comb begin
        w_sel_s  = SFP_ZERO;
        v_sel_s  = SFP_ZERO;
        nw_sel_s = SFP_ZERO;
        ng_sel_s = SFP_ZERO;
        for (int k = 0; k < N_IN; k++) begin
            if (idx_r == IW'(k)) begin
                w_sel_s = w_r[k];
                v_sel_s = vals_r[k];
            end else begin
                w_sel_s = w_sel_s;
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (oidx_r == OW'(k)) begin
                nw_sel_s = nw_r[k];
                ng_sel_s = ng_r[k];
            end else begin
                nw_sel_s = nw_sel_s;
            end
        end
    end

    // Backprop term gated for ReLU, and the weight-update value.
    always_comb begin
        term_s = sfp_mul_sat(nw_sel_s, ng_sel_s);
        if (act_r == ACT_RELU && acc_r < SFP_ZERO) term_s = SFP_ZERO;
        else                                       term_s = term_s;
        lrg_s = sfp_mul_sat(lr_r, err_r);
        if (upd_last_s) upd_new_s = sfp_sub_sat(bias_r, lrg_s);
        else            upd_new_s = sfp_sub_sat(w_sel_s, sfp_mul_sat(lrg_s, v_sel_s));
    end

    perceptron_seq_act_deriv u_deriv (
        .activation (act_r),
        .prediction (pred_r),
        .sum        (acc_r),
        .g          (g_r),
        .result     (deriv_s)
    );

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE:      state_nx = in_hs_s ? S_MAC : S_IDLE;
            S_MAC:       state_nx = mac_last_s ? S_ACT : S_MAC;
            S_ACT:       state_nx = S_OUT;
            S_OUT:       state_nx = bus.out_ready ? (train_r ? S_WAIT_GRAD : S_IDLE) : S_OUT;
            S_WAIT_GRAD: state_nx = bus.grad_valid ? S_BACK : S_WAIT_GRAD;
            S_BACK:      state_nx = back_last_s ? S_DERIV : S_BACK;
            S_DERIV:     state_nx = S_UPD;
            S_UPD:       state_nx = upd_last_s ? S_IDLE : S_UPD;
`ifdef PERCEPTRON_LFSR_INIT_EN
            S_INIT:      state_nx = upd_last_s ? S_IDLE : S_INIT;
`endif
            default:     state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= RESET_STATE;
        else        state_r <= state_nx;
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            grad_ready_r <= 1'b0;
            err_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= (state_nx == S_OUT);
            grad_ready_r <= (state_nx == S_WAIT_GRAD);
            err_valid_r  <= (state_r == S_DERIV);
        end
    end

`ifdef PERCEPTRON_LFSR_INIT_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 stepping during initialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 lfsr_r <= 16'hACE1;
        else if (state_r == S_INIT) lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        else                        lfsr_r <= lfsr_r;
    end
`endif

    // Weight/bias write port: external load in IDLE, update in UPD.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = {IW{1'b0}};
        wr_data_s = SFP_ZERO;
        if (state_r == S_IDLE && bus.wload_en) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = bus.wload_idx;
            wr_data_s = bus.wload_data;
        end else if (state_r == S_UPD) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx_r;
            wr_data_s = upd_new_s;
        end
`ifdef PERCEPTRON_LFSR_INIT_EN
        else if (state_r == S_INIT) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx_r;
            wr_data_s = sfp'({{8{lfsr_r[7]}}, lfsr_r[7:0]});
        end
`endif
        else begin
            wr_en_s = 1'b0;
        end
    end

    // Weight and bias registers; indices beyond N_IN match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++) w_r[k] <= SFP_ZERO;
            bias_r <= SFP_ZERO;
        end else if (wr_en_s) begin
            for (int k = 0; k < N_IN; k++) begin
                if (wr_idx_s == IW'(k)) w_r[k] <= wr_data_s;
            end
            if (wr_idx_s == IW'(N_IN)) bias_r <= wr_data_s;
        end
    end

    // Datapath: operand capture, MAC, activation, backprop and derivative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= {IW{1'b0}};
            oidx_r  <= {OW{1'b0}};
            acc_r   <= SFP_ZERO;
            pred_r  <= SFP_ZERO;
            g_r     <= SFP_ZERO;
            err_r   <= SFP_ZERO;
            lr_r    <= SFP_ZERO;
            act_r   <= ACT_LINEAR;
            train_r <= 1'b0;
            for (int k = 0; k < N_IN; k++)  vals_r[k] <= SFP_ZERO;
            for (int k = 0; k < N_OUT; k++) begin
                nw_r[k] <= SFP_ZERO;
                ng_r[k] <= SFP_ZERO;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_hs_s) begin
                        vals_r  <= bus.in_values;
                        act_r   <= bus.activation;
                        train_r <= bus.train;
                        acc_r   <= bias_r;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                S_MAC: begin
                    acc_r <= sfp_add_sat(acc_r, sfp_mul_sat(w_sel_s, v_sel_s));
                    idx_r <= mac_last_s ? {IW{1'b0}} : idx_r + IW'(1);
                end
                S_ACT: pred_r <= predict(act_r, acc_r);
                S_WAIT_GRAD: begin
                    if (bus.grad_valid) begin
                        nw_r   <= bus.next_weights;
                        ng_r   <= bus.next_grad;
                        lr_r   <= bus.learning_rate;
                        g_r    <= SFP_ZERO;
                        oidx_r <= {OW{1'b0}};
                    end
                end
                S_BACK: begin
                    g_r    <= sfp_add_sat(g_r, term_s);
                    oidx_r <= oidx_r + OW'(1);
                end
                S_DERIV: begin
                    err_r <= deriv_s;
                    idx_r <= {IW{1'b0}};
                end
                S_UPD:  idx_r <= idx_r + IW'(1);
`ifdef PERCEPTRON_LFSR_INIT_EN
                S_INIT: idx_r <= upd_last_s ? {IW{1'b0}} : idx_r + IW'(1);
`endif
                default: idx_r <= idx_r;
            endcase
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_r;
    assign bus.prediction      = pred_r;
    assign bus.grad_ready      = grad_ready_r;
    assign bus.err_valid       = err_valid_r;
    assign bus.error_gradient  = err_r;
    assign bus.current_weights = w_r;

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq (Q8.8, N_IN=2, N_OUT=2, LFSR init off).
module tb_perceptron_seq;
    import perceptron_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    perceptron_seq_if #(.N_IN(2), .N_OUT(2)) bus ();

    perceptron_seq #(.N_IN(2), .N_OUT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wload(input logic [1:0] idx, input logic [15:0] data);
        bus.wload_en   = 1'b1;
        bus.wload_idx  = idx;
        bus.wload_data = data;
        tick();
        bus.wload_en   = 1'b0;
    endtask

    task automatic start(input logic [15:0] v0, input logic [15:0] v1, input act_func f, input logic tr);
        bus.in_values[0] = v0;
        bus.in_values[1] = v1;
        bus.activation   = f;
        bus.train        = tr;
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid     = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp_pred);
        for (int k = 0; k < 16 && bus.out_valid !== 1'b1; k++) tick();
        check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
        check({tag, "_pred"}, bus.prediction, exp_pred);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic backprop(input string tag, input logic [15:0] nw0, input logic [15:0] nw1,
                            input logic [15:0] ng0, input logic [15:0] ng1,
                            input logic [15:0] lr, input logic [15:0] exp_err);
        check({tag, "_grad_ready"}, {15'd0, bus.grad_ready}, 16'd1);
        bus.next_weights[0] = nw0;
        bus.next_weights[1] = nw1;
        bus.next_grad[0]    = ng0;
        bus.next_grad[1]    = ng1;
        bus.learning_rate   = lr;
        bus.grad_valid      = 1'b1;
        tick();
        bus.grad_valid      = 1'b0;
        for (int k = 0; k < 16 && bus.err_valid !== 1'b1; k++) tick();
        check({tag, "_err_valid"}, {15'd0, bus.err_valid}, 16'd1);
        check({tag, "_err"}, bus.error_gradient, exp_err);
        tick();
        check({tag, "_err_pulse"}, {15'd0, bus.err_valid}, 16'd0);
        for (int k = 0; k < 16 && bus.in_ready !== 1'b1; k++) tick();
        check({tag, "_back_idle"}, {15'd0, bus.in_ready}, 16'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.grad_valid = 1'b0;
        bus.wload_en = 1'b0; bus.wload_idx = 2'd0; bus.wload_data = 16'h0000;
        bus.activation = ACT_LINEAR; bus.train = 1'b0; bus.learning_rate = 16'h0000;
        bus.in_values[0] = 16'h0000; bus.in_values[1] = 16'h0000;
        bus.next_weights[0] = 16'h0000; bus.next_weights[1] = 16'h0000;
        bus.next_grad[0] = 16'h0000; bus.next_grad[1] = 16'h0000;
        #12;
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_grad_ready", {15'd0, bus.grad_ready}, 16'd0);
        check("rst_err_valid", {15'd0, bus.err_valid}, 16'd0);
        check("rst_pred", bus.prediction, 16'h0000);
        check("rst_err", bus.error_gradient, 16'h0000);
        check("rst_w0", bus.current_weights[0], 16'h0000);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", {15'd0, bus.in_ready}, 16'd1);

        // Weight load has priority over a simultaneous in_valid.
        bus.wload_en = 1'b1; bus.wload_idx = 2'd0; bus.wload_data = 16'h0100;
        bus.in_valid = 1'b1;
        #1;
        check("wload_blocks_in_ready", {15'd0, bus.in_ready}, 16'd0);
        tick();
        bus.wload_en = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("wload_prio_still_idle", {15'd0, bus.in_ready}, 16'd1);
        wload(2'd1, 16'h0200);
        wload(2'd2, 16'h0080);
        wload(2'd3, 16'h1234);
        check("wload_w0", bus.current_weights[0], 16'h0100);
        check("wload_w1", bus.current_weights[1], 16'h0200);

        // ReLU forward: 0.5 + 1*1 + 2*0.5 = 2.5, out_valid in cycle 4.
        start(16'h0100, 16'h0080, ACT_RELU, 1'b0);
        tick();
        check("lat_c2", {15'd0, bus.out_valid}, 16'd0);
        tick();
        check("lat_c3", {15'd0, bus.out_valid}, 16'd0);
        tick();
        check("lat_c4", {15'd0, bus.out_valid}, 16'd1);
        check("relu_pred", bus.prediction, 16'h0280);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_valid", {15'd0, bus.out_valid}, 16'd1);
            check("hold_pred", bus.prediction, 16'h0280);
            check("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("one_handshake", {15'd0, bus.out_valid}, 16'd0);
        check("back_to_idle", {15'd0, bus.in_ready}, 16'd1);

        // Training pass: g = 1*0.5 + 0.5*1 = 1.0; lr 0.5 -> w {0.5, 1.75}, bias 0.
        start(16'h0100, 16'h0080, ACT_RELU, 1'b1);
        wait_out("train_fwd", 16'h0280);
        backprop("train", 16'h0100, 16'h0080, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
        check("upd_w0", bus.current_weights[0], 16'h0080);
        check("upd_w1", bus.current_weights[1], 16'h01C0);
        // Linear, v={1,0}: 0.5*1 + bias 0 = 0.5.
        start(16'h0100, 16'h0000, ACT_LINEAR, 1'b0);
        wait_out("upd_bias", 16'h0080);

        // Saturation: 127*127 clips to max, accumulation does not wrap.
        wload(2'd0, 16'h7F00);
        wload(2'd1, 16'h7F00);
        start(16'h7F00, 16'h7F00, ACT_RELU, 1'b0);
        wait_out("sat", 16'h7FFF);

        // Reset in the middle of MAC aborts immediately.
        start(16'h0100, 16'h0100, ACT_RELU, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("abort_w0", bus.current_weights[0], 16'h0000);
        check("abort_w1", bus.current_weights[1], 16'h0000);
        rst_n = 1'b1;
        tick();
        check("abort_idle", {15'd0, bus.in_ready}, 16'd1);
        check("abort_out_valid_next", {15'd0, bus.out_valid}, 16'd0);

        // Sigmoid at 0 -> 0.5; gradient 1.0 * 0.5 * 0.5 = 0.25; lr 1 -> w0 = -0.25.
        start(16'h0100, 16'h0000, ACT_SIGMOID, 1'b1);
        wait_out("sig_fwd", 16'h0080);
        backprop("sig", 16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0100, 16'h0040);
        check("sig_w0", bus.current_weights[0], 16'hFFC0);
        check("sig_w1", bus.current_weights[1], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
